// File: rtl/cost_pkg.sv
// cost_pkg: shared sizes and FSM state type for the cost feeder.
package cost_pkg;
    localparam int N      = 8;
    localparam int COST_W = 7;
    localparam int SUM_W  = 13;
    localparam int MIN_W  = 10;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {LOAD, SERVE, DONE} state_t;
endpackage

// File: rtl/cost_mem.sv
// cost_mem: 64x7 cost table with one write port and one registered read port.
module cost_mem
    import cost_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [5:0]        waddr,
    input  logic [COST_W-1:0] wdata,
    input  logic [5:0]        raddr,
    output logic [COST_W-1:0] rdata
);
    logic [COST_W-1:0] mem [N*N];

    // write port; contents deliberately survive reset
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    // registered read port, cleared by reset
    always_ff @(posedge clk)
        if (!rst_n) rdata <= '0;
        else rdata <= mem[raddr];
endmodule

// File: rtl/cost_feeder.sv
// cost_feeder: loads a 64-entry cost table, serves it to an assignment engine and captures its result.
// Optional load checksum is enabled by defining COST_FEEDER_CHK_EN.
module cost_feeder
    import cost_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [COST_W-1:0] in_data,
    output logic              in_ready,
    input  logic [SUM_W-1:0]  chk,
    output logic              jam_rst,
    input  logic [2:0]        w,
    input  logic [2:0]        j,
    output logic [COST_W-1:0] cost,
    input  logic              jam_valid,
    input  logic [MIN_W-1:0]  jam_min,
    input  logic [CNT_W-1:0]  jam_cnt,
    output logic              res_valid,
    output logic [MIN_W-1:0]  res_min,
    output logic [CNT_W-1:0]  res_cnt,
    output logic              err
);
    state_t     state;
    logic [5:0] idx;
    logic       accept;
    logic       last;
    logic       load_ok;

    assign accept   = rst_n && in_valid && state == LOAD;
    assign last     = accept && idx == 6'd63;
    assign in_ready = state == LOAD;
    assign jam_rst  = state != SERVE;

`ifdef COST_FEEDER_CHK_EN
    logic [SUM_W-1:0] sum;

    assign load_ok = (sum + SUM_W'(in_data)) == chk;

    // running sum of the current load; restarts whenever a new load begins
    always_ff @(posedge clk)
        if (!rst_n || last || state == DONE) sum <= '0;
        else if (accept) sum <= sum + SUM_W'(in_data);

    // one-cycle pulse when the completed load disagrees with the checksum
    always_ff @(posedge clk)
        if (!rst_n) err <= 1'b0;
        else err <= last && !load_ok;
`else
    logic unused_chk;

    assign unused_chk = ^chk;
    assign load_ok    = 1'b1;
    assign err        = 1'b0;
`endif

    cost_mem u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept),
        .waddr (idx),
        .wdata (in_data),
        .raddr ({w, j}),
        .rdata (cost)
    );

    // load / serve / done sequencing with result capture
    always_ff @(posedge clk)
        if (!rst_n) begin
            state     <= LOAD;
            idx       <= '0;
            res_valid <= 1'b0;
            res_min   <= '1;
            res_cnt   <= '0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                LOAD: if (accept) begin
                    idx <= idx + 6'd1;
                    if (last && load_ok) state <= SERVE;
                end
                SERVE: if (jam_valid) begin
                    res_valid <= 1'b1;
                    res_min   <= jam_min;
                    res_cnt   <= jam_cnt;
                    state     <= DONE;
                end
                default: begin
                    idx   <= '0;
                    state <= LOAD;
                end
            endcase
        end
endmodule

// File: doc/cost_feeder.md
COST_FEEDER -- requirements
Module: cost_feeder

Interface
REQ-001 CLK  input  1  single rising-edge clock for all state.
REQ-002 RST_N  input  1  reset; synchronous, active-low.
REQ-003 IN_VALID  input  1  upstream cost beat valid.
REQ-004 IN_DATA  input  7  cost value, row-major order: worker W outer, job J inner.
REQ-005 IN_READY  output  1  high while in LOAD.
REQ-006 CHK  input  13  expected sum of all 64 costs, sampled with the 64th accepted beat.
REQ-007 JAM_RST  output  1  active-high reset to the assignment engine.
REQ-008 W  input  3  worker index requested by the engine.
REQ-009 J  input  3  job index requested by the engine.
REQ-010 Cost  output  7  registered table[W][J].
REQ-011 JAM_VALID, JAM_MIN, JAM_CNT  input  1/10/4  engine result handshake, minimum cost and match count.
REQ-012 RES_VALID, RES_MIN, RES_CNT  output  1/10/4  one-cycle result pulse and captured values.
REQ-013 ERR  output  1  one-cycle checksum-mismatch pulse.

Function
REQ-014 The FSM has states LOAD, SERVE and DONE; the reset state is LOAD.
REQ-015 In LOAD, a beat is accepted when IN_VALID && IN_READY and written to table[idx[5:3]][idx[2:0]]; the 6-bit idx then increments.
REQ-016 The accepted beat at idx==63 completes the load, wraps idx to 0 and moves the FSM to SERVE on the next cycle.
REQ-017 JAM_RST is 1 in LOAD and DONE and 0 in SERVE, so the engine starts its read sweep on the first SERVE cycle.
REQ-018 Cost is updated every cycle to table[W][J] with 1-cycle latency, in all states, and is never combinational.
REQ-019 IN_VALID is ignored outside LOAD and IN_READY is 0 outside LOAD.
REQ-020 In SERVE, JAM_VALID==1 captures JAM_MIN into RES_MIN and JAM_CNT into RES_CNT, pulses RES_VALID for exactly one cycle and moves the FSM to DONE.
REQ-021 JAM_VALID is ignored in LOAD and DONE.
REQ-022 DONE lasts exactly one cycle, then returns to LOAD with idx=0; table contents are retained until overwritten.
REQ-023 RES_MIN and RES_CNT hold their values until the next capture.

Reset
REQ-024 When RST_N==0 at a clock edge: state=LOAD, idx=0, Cost=0, JAM_RST=1, RES_VALID=0, RES_MIN=10'h3FF, RES_CNT=0, ERR=0, sum=0.
REQ-025 Table contents are not reset.
REQ-026 Reset during LOAD discards the partial load, and the next load restarts at idx 0.
REQ-027 Reset during SERVE re-asserts JAM_RST on the following cycle.

Configuration
REQ-028 The macro COST_FEEDER_CHK_EN controls the checksum.
REQ-029 With COST_FEEDER_CHK_EN defined, a 13-bit sum accumulates every accepted beat.
REQ-030 With the checksum enabled, on the 64th beat the value (sum + IN_DATA) is compared with CHK; on match the FSM enters SERVE.
REQ-031 With the checksum enabled, on mismatch ERR pulses one cycle, the FSM stays in LOAD, and idx and sum return to 0.
REQ-032 The sum clears on every LOAD entry.
REQ-033 Without COST_FEEDER_CHK_EN, CHK is ignored, ERR is tied to 0, no sum register exists, and the 64th beat always enters SERVE.

Structure
REQ-034 Package cost_pkg holds N=8, COST_W=7, SUM_W=13, MIN_W=10, CNT_W=4 and the state enum typedef.
REQ-035 Sub-module cost_mem is a 64x7 register array with one write port and one registered read port, instantiated once.

Verification
REQ-036 Load costs table[w][j]=(w*8+j)%128 with IN_VALID held high: IN_READY falls after 64 beats, JAM_RST falls on the next cycle, and W=3,J=5 gives Cost=29 one cycle later.
REQ-037 Deassert IN_VALID on every other cycle during the load: exactly 64 accepted beats, and idx never skips or double-writes.
REQ-038 In SERVE, drive JAM_VALID=1 with JAM_MIN=10'd37 and JAM_CNT=4'd2: RES_VALID pulses 1 cycle, RES_MIN=37, RES_CNT=2, JAM_RST returns to 1 after the one-cycle DONE, and the FSM is in LOAD.
REQ-039 With the checksum enabled, send all-ones costs with CHK=8128: the FSM enters SERVE; send CHK=8127: ERR pulses, the FSM stays in LOAD and the next beat writes idx 0.
REQ-040 Drop RST_N after 30 beats, then reload a full 64: the table matches the second stream at all 64 addresses and JAM_RST is held high throughout the interrupted load.
REQ-041 Drive IN_VALID in SERVE and JAM_VALID in LOAD: no table write and no RES_VALID pulse.
